// File: rtl/sindoku_check_ctrl.sv
// Sudoku board checker controller.
// In IDLE it grants user cell writes to the puzzle RAM. On Start it scans all
// 81 cells, compares each RAM cell with the solution ROM one cycle later, and
// reports the mismatch count and the first mismatching cell.
module sindoku_check_ctrl (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       abort_i,
    input  logic       ack_i,
    input  logic       wr_req_i,
    input  logic [3:0] wr_row_i,
    input  logic [3:0] wr_col_i,
    input  logic [3:0] wr_val_i,
    output logic       wr_gnt_o,
    output logic [6:0] ram_addr_o,
    output logic       ram_we_o,
    output logic [3:0] ram_wdata_o,
    input  logic [3:0] ram_rdata_i,
    input  logic [3:0] sol_data_i,
    output logic       q_idle_o,
    output logic       q_scan_o,
    output logic       q_drain_o,
    output logic       q_done_o,
    output logic       correct_o,
    output logic       incorrect_o,
    output logic [6:0] err_count_o,
    output logic [3:0] first_err_row_o,
    output logic [3:0] first_err_col_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DRAIN, ST_DONE} state_e;

    localparam logic [6:0] LAST_CELL = 7'd80;
    localparam logic [3:0] NO_CELL   = 4'hF;

    state_e     state_q, state_d;
    logic [6:0] idx_q;
    logic [3:0] scan_row_q, scan_col_q;
    logic       cmp_valid_q;
    logic [3:0] cmp_row_q, cmp_col_q;
    logic [6:0] err_count_q;
    logic [3:0] first_row_q, first_col_q;

    logic       wr_in_range, wr_gnt, start_acc, abort_acc, mismatch;
    logic [6:0] wr_addr;

    assign wr_in_range = (wr_row_i <= 4'd8) && (wr_col_i <= 4'd8);
    assign wr_gnt      = (state_q == ST_IDLE) && wr_req_i && wr_in_range;
    // A granted write takes priority over Start in the same cycle.
    assign start_acc   = (state_q == ST_IDLE) && start_i && !wr_gnt;
    assign abort_acc   = ((state_q == ST_SCAN) || (state_q == ST_DRAIN)) && abort_i;
    assign wr_addr     = {3'b000, wr_row_i} * 7'd9 + {3'b000, wr_col_i};
    // An empty cell never matches, even if the solution were somehow 0.
    assign mismatch    = (ram_rdata_i == 4'd0) || (ram_rdata_i != sol_data_i);

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned
        // (which would infer a latch).
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_acc) state_d = ST_SCAN;
            ST_SCAN: begin
                if (abort_i)                 state_d = ST_IDLE;
                else if (idx_q == LAST_CELL) state_d = ST_DRAIN;
            end
            ST_DRAIN: state_d = abort_i ? ST_IDLE : ST_DONE;
            ST_DONE:  if (ack_i) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs: one-hot state flags, RAM port muxing, result flags.
    always_comb begin
        q_idle_o    = (state_q == ST_IDLE);
        q_scan_o    = (state_q == ST_SCAN);
        q_drain_o   = (state_q == ST_DRAIN);
        q_done_o    = (state_q == ST_DONE);
        ram_addr_o  = 7'd0;
        ram_we_o    = 1'b0;
        ram_wdata_o = 4'd0;
        wr_gnt_o    = 1'b0;
        correct_o   = 1'b0;
        incorrect_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wr_gnt) begin
                    ram_addr_o  = wr_addr;
                    ram_we_o    = 1'b1;
                    ram_wdata_o = wr_val_i;
                    wr_gnt_o    = 1'b1;
                end
            end
            ST_SCAN: ram_addr_o = idx_q;
            ST_DONE: begin
                correct_o   = (err_count_q == 7'd0);
                incorrect_o = (err_count_q != 7'd0);
            end
            default: ;
        endcase
    end

    // Scan counters and compare pipeline; the compare runs one cycle behind the address.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx_q       <= 7'd0;
            scan_row_q  <= 4'd0;
            scan_col_q  <= 4'd0;
            cmp_valid_q <= 1'b0;
            cmp_row_q   <= 4'd0;
            cmp_col_q   <= 4'd0;
            err_count_q <= 7'd0;
            first_row_q <= NO_CELL;
            first_col_q <= NO_CELL;
        end else begin
            cmp_valid_q <= (state_q == ST_SCAN) && !abort_i;
            cmp_row_q   <= scan_row_q;
            cmp_col_q   <= scan_col_q;
            if (start_acc || abort_acc) begin
                idx_q       <= 7'd0;
                scan_row_q  <= 4'd0;
                scan_col_q  <= 4'd0;
                err_count_q <= 7'd0;
                first_row_q <= NO_CELL;
                first_col_q <= NO_CELL;
            end else begin
                if (state_q == ST_SCAN) begin
                    idx_q <= idx_q + 7'd1;
                    if (scan_col_q == 4'd8) begin
                        scan_col_q <= 4'd0;
                        scan_row_q <= scan_row_q + 4'd1;
                    end else begin
                        scan_col_q <= scan_col_q + 4'd1;
                    end
                end
                if (cmp_valid_q && mismatch) begin
                    err_count_q <= err_count_q + 7'd1;
                    if (first_row_q == NO_CELL) begin
                        first_row_q <= cmp_row_q;
                        first_col_q <= cmp_col_q;
                    end
                end
            end
        end
    end

    assign err_count_o     = err_count_q;
    assign first_err_row_o = first_row_q;
    assign first_err_col_o = first_col_q;

endmodule

// File: tb/tb_sindoku_check_ctrl.sv
// Self-checking bench for sindoku_check_ctrl: behavioural puzzle RAM and
// solution ROM, a table of IDLE write vectors, a scoreboard of expected
// check results, and hand-written abort / reset / priority sequences.
module tb_sindoku_check_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, abort, ack, wr_req;
    logic [3:0] wr_row, wr_col, wr_val;
    logic       wr_gnt, ram_we;
    logic [6:0] ram_addr;
    logic [3:0] ram_wdata, ram_rdata, sol_data;
    logic       q_idle, q_scan, q_drain, q_done, correct, incorrect;
    logic [6:0] err_count;
    logic [3:0] first_row, first_col;

    sindoku_check_ctrl dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort), .ack_i(ack),
        .wr_req_i(wr_req), .wr_row_i(wr_row), .wr_col_i(wr_col), .wr_val_i(wr_val),
        .wr_gnt_o(wr_gnt), .ram_addr_o(ram_addr), .ram_we_o(ram_we), .ram_wdata_o(ram_wdata),
        .ram_rdata_i(ram_rdata), .sol_data_i(sol_data),
        .q_idle_o(q_idle), .q_scan_o(q_scan), .q_drain_o(q_drain), .q_done_o(q_done),
        .correct_o(correct), .incorrect_o(incorrect), .err_count_o(err_count),
        .first_err_row_o(first_row), .first_err_col_o(first_col)
    );

    always #5 clk = ~clk;

    // Puzzle RAM (written by the DUT or bulk-loaded from img) and solution ROM.
    logic [3:0] board [81];
    logic [3:0] img   [81];
    logic [3:0] sol   [81];
    logic       load_en;

    always @(posedge clk) begin
        if (ram_we && ram_addr < 7'd81) board[ram_addr] <= ram_wdata;
        else if (load_en) for (int i = 0; i < 81; i++) board[i] <= img[i];
        ram_rdata <= (ram_addr < 7'd81) ? board[ram_addr] : 4'd0;
        sol_data  <= (ram_addr < 7'd81) ? sol[ram_addr]   : 4'd0;
    end

    typedef struct {
        logic [6:0] err;
        logic [3:0] frow;
        logic [3:0] fcol;
    } exp_t;

    typedef struct {
        logic       req;
        logic [3:0] row;
        logic [3:0] col;
        logic [3:0] val;
        logic       exp_gnt;
        logic [6:0] exp_addr;
    } wr_vec_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Independent reference: count mismatches of img against sol.
    function automatic exp_t model();
        exp_t e;
        e.err  = 7'd0;
        e.frow = 4'hF;
        e.fcol = 4'hF;
        for (int i = 0; i < 81; i++) begin
            if (img[i] == 4'd0 || img[i] != sol[i]) begin
                if (e.err == 7'd0) begin
                    e.frow = 4'(i / 9);
                    e.fcol = 4'(i % 9);
                end
                e.err = e.err + 7'd1;
            end
        end
        return e;
    endfunction

    task automatic load_board();
        load_en = 1'b1;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic img_from_sol();
        for (int i = 0; i < 81; i++) img[i] = sol[i];
    endtask

    // Full check run from IDLE; expected result goes to the scoreboard at Start.
    task automatic run_check(input string tag, input logic ack_early, input logic wr_scan);
        exp_t e;
        int   n, bad_addr, gnt_seen;
        sb_q.push_back(model());
        start = 1'b1;
        ack   = ack_early;
        @(negedge clk);
        start = 1'b0;
        check({tag, ":enter_scan"}, q_scan, 1);
        n = 0; bad_addr = 0; gnt_seen = 0;
        while (q_scan === 1'b1 && n < 200) begin
            if (wr_scan) begin
                wr_req = 1'b1; wr_row = 4'(n % 9); wr_col = 4'd0; wr_val = 4'd1;
            end
            #1;
            if (ram_addr !== 7'(n) || ram_we !== 1'b0) bad_addr++;
            if (wr_gnt !== 1'b0) gnt_seen++;
            n++;
            @(negedge clk);
        end
        wr_req = 1'b0;
        check({tag, ":scan_cycles"}, n, 81);
        check({tag, ":scan_addr_errs"}, bad_addr, 0);
        check({tag, ":gnt_in_scan"}, gnt_seen, 0);
        check({tag, ":drain"}, q_drain, 1);
        @(negedge clk);
        check({tag, ":done"}, q_done, 1);
        if (sb_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL %s:scoreboard got empty queue expected entry", tag);
        end else begin
            e = sb_q.pop_front();
            check({tag, ":err_count"}, err_count, e.err);
            check({tag, ":first_row"}, first_row, e.frow);
            check({tag, ":first_col"}, first_col, e.fcol);
            check({tag, ":correct"}, correct, (e.err == 7'd0));
            check({tag, ":incorrect"}, incorrect, (e.err != 7'd0));
            ack = 1'b1;
            @(negedge clk);
            ack = 1'b0;
            check({tag, ":ack_idle"}, q_idle, 1);
            check({tag, ":result_held"}, err_count, e.err);
        end
    endtask

    wr_vec_t vecs [8];
    int      n;

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; ack = 1'b0; load_en = 1'b0;
        wr_req = 1'b0; wr_row = 4'd0; wr_col = 4'd0; wr_val = 4'd0;
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++)
                sol[r * 9 + c] = 4'(((r * 3 + r / 3 + c) % 9) + 1);
        img_from_sol();

        vecs[0] = '{1'b1, 4'd0,  4'd0,  4'd3, 1'b1, 7'd0};
        vecs[1] = '{1'b1, 4'd8,  4'd8,  4'd9, 1'b1, 7'd80};
        vecs[2] = '{1'b1, 4'd9,  4'd0,  4'd1, 1'b0, 7'd0};
        vecs[3] = '{1'b1, 4'd0,  4'd9,  4'd1, 1'b0, 7'd0};
        vecs[4] = '{1'b1, 4'd15, 4'd15, 4'd2, 1'b0, 7'd0};
        vecs[5] = '{1'b0, 4'd4,  4'd5,  4'd7, 1'b0, 7'd0};
        vecs[6] = '{1'b1, 4'd2,  4'd7,  4'd0, 1'b1, 7'd25};
        vecs[7] = '{1'b1, 4'd8,  4'd0,  4'd5, 1'b1, 7'd72};

        // Reset state.
        #2;
        check("rst:q_idle", q_idle, 1);
        check("rst:q_others", {q_scan, q_drain, q_done}, 0);
        check("rst:err_count", err_count, 0);
        check("rst:first", {first_row, first_col}, 8'hFF);
        check("rst:flags", {correct, incorrect}, 0);
        check("rst:ram", {ram_we, wr_gnt, ram_addr}, 0);
        @(negedge clk);
        rst = 1'b0;

        // IDLE write-grant table.
        foreach (vecs[i]) begin
            wr_req = vecs[i].req; wr_row = vecs[i].row;
            wr_col = vecs[i].col; wr_val = vecs[i].val;
            #1;
            check($sformatf("wr%0d:gnt", i), wr_gnt, vecs[i].exp_gnt);
            check($sformatf("wr%0d:we", i), ram_we, vecs[i].exp_gnt);
            check($sformatf("wr%0d:addr", i), ram_addr, vecs[i].exp_addr);
            if (vecs[i].exp_gnt) check($sformatf("wr%0d:wdata", i), ram_wdata, vecs[i].val);
            check($sformatf("wr%0d:idle", i), q_idle, 1);
            @(negedge clk);
        end
        wr_req = 1'b0;

        // A: board equals solution.
        img_from_sol();
        load_board();
        run_check("A", 1'b0, 1'b0);

        // B: (0,0) empty and (8,8) wrong; Ack held and writes requested during scan.
        img_from_sol();
        img[0]  = 4'd0;
        img[80] = (sol[80] % 4'd9) + 4'd1;
        load_board();
        run_check("B", 1'b1, 1'b1);

        // C: only (8,8) wrong, exercising the drain compare.
        img_from_sol();
        img[80] = (sol[80] % 4'd9) + 4'd1;
        load_board();
        run_check("C", 1'b0, 1'b0);

        // D: random corruption.
        img_from_sol();
        for (int k = 0; k < 6; k++) img[$urandom_range(0, 80)] = 4'($urandom_range(0, 9));
        load_board();
        run_check("D", 1'b0, 1'b0);

        // E: write beats Start, then Start accepted, then abort at index 40.
        img_from_sol();
        img[3]  = 4'd0;
        img[10] = (sol[10] % 4'd9) + 4'd1;
        load_board();
        start = 1'b1; wr_req = 1'b1; wr_row = 4'd4; wr_col = 4'd5; wr_val = 4'd7;
        #1;
        check("E:wr_addr", ram_addr, 41);
        check("E:wr_we_gnt", {ram_we, wr_gnt}, 2'b11);
        check("E:wr_idle", q_idle, 1);
        @(negedge clk);
        wr_req = 1'b0;
        check("E:still_idle", q_idle, 1);
        @(negedge clk);
        start = 1'b0;
        check("E:scan", q_scan, 1);
        check("E:ram_written", board[41], 7);
        n = 0;
        while (ram_addr !== 7'd40 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("E:reached_40", ram_addr, 40);
        check("E:partial_err", err_count, 2);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("E:abort_idle", q_idle, 1);
        check("E:abort_err", err_count, 0);
        check("E:abort_first", {first_row, first_col}, 8'hFF);

        // F: reset asserted at index 60, then a clean check afterwards.
        img_from_sol();
        img[80] = (sol[80] % 4'd9) + 4'd1;
        img[5]  = 4'd0;
        load_board();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (ram_addr !== 7'd60 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("F:reached_60", ram_addr, 60);
        rst = 1'b1;
        #1;
        check("F:rst_idle", {q_idle, q_scan, q_drain, q_done}, 4'b1000);
        check("F:rst_err", err_count, 0);
        check("F:rst_first", {first_row, first_col}, 8'hFF);
        check("F:rst_ram", {ram_we, wr_gnt, ram_addr}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("F:post_idle", q_idle, 1);
        check("F:post_flags", {correct, incorrect, err_count}, 0);
        run_check("F", 1'b0, 1'b0);

        check("sb_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sindoku_check_ctrl.md
SINDOKU_CHECK_CTRL -- requirements
Module: sindoku_check_ctrl

Interface
REQ-001 Clk  in  1  single system clock; all state changes on rising edge.
REQ-002 Reset  in  1  asynchronous, active-high; forces the reset state of REQ-030 immediately.
REQ-003 Start  in  1  level; request a full-board check.
REQ-004 Abort  in  1  level; cancel a check in progress.
REQ-005 Ack  in  1  level; acknowledge the result and return to idle.
REQ-006 WrReq  in  1  user cell-write request.
REQ-007 WrRow, WrCol  in  4 each  target cell, valid range 0..8.
REQ-008 WrVal  in  4  value to write, 0 = empty, 1..9 = digit.
REQ-009 WrGnt  out  1  one-cycle pulse: the write was performed this cycle.
REQ-010 RamAddr  out  7  puzzle RAM address = row*9+col, 0..80.
REQ-011 RamWe  out  1  puzzle RAM write enable; RamWData  out  4  write data.
REQ-012 RamRData  in  4  puzzle RAM read data; registered, valid one cycle after RamAddr.
REQ-013 SolData  in  4  solution ROM data; ROM shares RamAddr and has the same 1-cycle latency.
REQ-014 q_Idle, q_Scan, q_Drain, q_Done  out  1 each  one-hot state outputs.
REQ-015 Correct, Incorrect  out  1 each  result flags, valid in DONE only.
REQ-016 ErrCount  out  7  number of mismatching cells, 0..81.
REQ-017 FirstErrRow, FirstErrCol  out  4 each  lowest-address mismatching cell; 4'hF when none.

Function
REQ-018 States: IDLE, SCAN, DRAIN, DONE; exactly one q_* output is high at any time.
REQ-019 IDLE, WrReq=1, WrRow<=8, WrCol<=8: RamWe=1, RamAddr=WrRow*9+WrCol, RamWData=WrVal, WrGnt=1, all in the same cycle (combinational grant).
REQ-020 IDLE, WrReq=1 with WrRow>8 or WrCol>8: RamWe=0, WrGnt=0, no other effect.
REQ-021 WrReq outside IDLE: RamWe=0, WrGnt=0; the request is ignored, not queued.
REQ-022 IDLE, Start=1 with no granted write that cycle: next state SCAN; ErrCount cleared to 0, FirstErrRow/Col set to 4'hF, cell index set to 0.
REQ-023 IDLE, Start=1 and a write granted the same cycle: the write wins, state stays IDLE; Start is accepted on the next cycle if still high.
REQ-024 SCAN: RamAddr = cell index, RamWe=0; index increments by 1 per cycle; index 80 is presented on the last SCAN cycle, then next state DRAIN. Exactly 81 SCAN cycles.
REQ-025 Compare pipeline: on each cycle following a SCAN cycle with address a, RamRData is compared with SolData; on mismatch ErrCount increments by 1 and, if FirstErrRow=4'hF, FirstErrRow/Col latch a/9 and a%9.
REQ-026 An empty cell (RamRData=0) counts as a mismatch.
REQ-027 DRAIN: one cycle; completes the compare for address 80; next state DONE.
REQ-028 DONE: Correct = (ErrCount==0), Incorrect = (ErrCount!=0); outputs held until Ack=1, then next state IDLE. Results remain readable in IDLE until the next accepted Start.
REQ-029 Abort=1 in SCAN or DRAIN: next state IDLE; ErrCount=0, FirstErrRow/Col=4'hF; any in-flight compare is discarded. Abort is ignored in IDLE and DONE; Ack is ignored outside DONE; Start is ignored outside IDLE.

Reset
REQ-030 On Reset: state IDLE, index 0, ErrCount=0, FirstErrRow/Col=4'hF, Correct=Incorrect=0, RamWe=0, WrGnt=0, RamAddr=0.
REQ-031 Reset asserted mid-SCAN or mid-DRAIN aborts immediately with the REQ-030 values; no partial result is visible after release.
REQ-032 First rising edge after Reset release evaluates IDLE normally.

Verification
REQ-033 Board equal to solution, Start one cycle -> q_Scan for 81 cycles, q_Drain 1 cycle, q_Done with Correct=1, ErrCount=0, FirstErrRow/Col=F/F; Ack -> q_Idle next cycle.
REQ-034 Board with cells (0,0)=0 and (8,8) wrong -> DONE with Incorrect=1, ErrCount=2, FirstErrRow=0, FirstErrCol=0; single-error case at (8,8) only -> ErrCount=1, First=8/8 (checks DRAIN compare).
REQ-035 IDLE, WrReq row=4 col=5 val=7 with Start high -> RamAddr=41, RamWe=1, WrGnt=1, state IDLE; next cycle Start accepted -> q_Scan.
REQ-036 WrReq row=9 col=0 in IDLE -> WrGnt=0, RamWe=0; WrReq during SCAN -> WrGnt=0, scan addresses uninterrupted.
REQ-037 Abort at SCAN index 40 -> q_Idle next cycle, ErrCount=0; Reset asserted at index 60 -> immediate q_Idle, all REQ-030 values.
REQ-038 Ack held high through SCAN -> no effect until DONE, then exit to IDLE after one DONE cycle.
